canbus_tx_scheduler: RTL and testbench
======================================

// Module: canbus_tx_scheduler
// PURPOSE
//  Shares one CAN frame transmitter between NUM_MB mailboxes (velocity, setpoint, status...).
//  Holds each mailbox request until it completes, picks the winner by CAN ID, launches the frame,
//  retries a frame that gets no ACK and enforces inter-frame spacing.
//  Sits between the plugin register file and the bit-level CAN transmitter.
// PARAMETERS
//  NUM_MB        4     number of mailboxes (1..8)
//  DATA_BITS     32    payload width per mailbox (DLC fixed = DATA_BITS/8)
//  MAX_RETRY     3     retries after the first attempt before a mailbox is dropped
//  IFS_TICKS     11    bit-time ticks of recessive gap after each frame
//  TIMEOUT_TICKS 200   bit-time ticks without frm_done before an attempt is aborted
// PORTS
//  clk         in   1               system clock
//  rst_n       in   1               asynchronous active-low reset
//  tick        in   1               1-clk strobe, one per CAN bit time
//  enable      in   1               0: no new launches; an attempt in flight completes
//  mb_req      in   NUM_MB          level request per mailbox; sampled when scheduler is idle
//  mb_id       in   NUM_MB*11       11-bit ID per mailbox, mailbox i at [i*11 +: 11]
//  mb_data     in   NUM_MB*DATA_BITS  payload per mailbox
//  mb_done     out  NUM_MB          1-clk pulse: frame ACKed
//  mb_err      out  NUM_MB          1-clk pulse: dropped after retries exhausted
//  frm_start   out  1               1-clk launch pulse to transmitter
//  frm_id      out  11              held stable from frm_start until frm_done
//  frm_data    out  DATA_BITS       held stable from frm_start until frm_done
//  frm_done    in   1               1-clk pulse: attempt finished
//  frm_acked   in   1               valid with frm_done: 1 = ACK slot dominant
//  active_mb   out  3               index of current/last launched mailbox
//  retry_cnt   out  8               saturating count of all retries since reset
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, pending mask 0, attempt counter 0.
//  Pending: pend[i] set on clk where mb_req[i]=1 and not in flight;
//    pend[i] cleared the same clk as mb_done[i] or mb_err[i] is pulsed.
//  States:
//   IDLE   : if enable and pend!=0 -> ARB next clk.
//   ARB    : winner = pending mailbox with lowest mb_id. Ties go to lowest index.
//            Latch its id/data into frm_id/frm_data and active_mb. Attempt counter = 0 -> LAUNCH.
//   LAUNCH : frm_start=1 for exactly one clk; clear timeout counter -> WAIT.
//   WAIT   : count ticks. On frm_done:
//            frm_acked=1 -> mb_done pulse, -> GAP.
//            else if attempts<MAX_RETRY -> attempts++, retry_cnt++, -> GAP then relaunch the same mailbox.
//            else -> mb_err pulse, -> GAP.
//            Timeout count reaching TIMEOUT_TICKS with no frm_done counts as a nACK attempt.
//            A frm_done in that same clk takes precedence.
//   GAP    : wait IFS_TICKS ticks.
//            If a retry is pending and enable=1 -> LAUNCH, with no re-arbitration; a retry owns the bus.
//            If a retry is pending and enable=0 -> IDLE, and the mailbox stays pending.
//            Otherwise -> IDLE.
//  Latency: pend set -> frm_start = 3 clks when idle (IDLE, ARB, LAUNCH).
//  frm_done outside WAIT is ignored. mb_req deassert while pending does not cancel the request.
//  mb_req re-assert in the clk of its mb_done re-arms pend next clk. The frame is sent again.
//  A tick coinciding with a state change counts toward the new state's counter.
//  retry_cnt saturates at 255. No wrap.
//  Reset mid-frame: frm_start/frm_id/frm_data drop to 0 at once. The transmitter is reset by the same rst_n.
// STRUCTURE
//  canbus_pkg: ID_W=11, state enum {IDLE,ARB,LAUNCH,WAIT,GAP}, CAN_MAX_DLC.
//  One sub-module: canbus_sched_pick.
//    Purely combinational lowest-ID/lowest-index picker over pend, mb_id.
//    Returns winner index and a valid flag.
//  Top holds the FSM, pending mask, tick counters and retry counters.
// TESTING
//  1. mb_req=0001, id0=0x00D, data0=0x12345678, ack on first try
//     -> frm_start 3 clks later, frm_id=0x00D, frm_data=0x12345678, mb_done=0001, GAP=11 ticks.
//  2. mb_req=1110 same clk with ids 0x200, 0x00D, 0x00D
//     -> order mb1, mb2, mb3. active_mb 1 then 2 then 3. Three mb_done pulses.
//  3. frm_acked=0 always, MAX_RETRY=3
//     -> 4 frm_start pulses, retry_cnt=3, mb_err[0] pulse, pend cleared.
//  4. frm_done never returns -> abort after 200 ticks. Retry as in 3.
//     frm_done on tick 200 -> treated as real done.
//  5. enable=0 during WAIT with nACK -> frame completes.
//     No relaunch while enable=0. Relaunch after enable=1, same mailbox.
//  6. rst_n low during WAIT
//     -> all outputs 0 asynchronously. After release, pend=0 and no frm_start until a new mb_req.

Source files
------------

// File: rtl/canbus_pkg.sv
// Shared types and constants for the CAN transmit scheduler.
package canbus_pkg;
    localparam int ID_W        = 11;
    localparam int CAN_MAX_DLC = 8;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        LAUNCH,
        WAIT,
        GAP
    } sched_state_t;
endpackage

// File: rtl/canbus_sched_pick.sv
// Combinational picker: pending mailbox with the lowest CAN ID, ties to the lowest index.
module canbus_sched_pick
    import canbus_pkg::*;
#(
    parameter int NUM_MB = 4
) (
    input  logic [NUM_MB-1:0]      pend,
    input  logic [NUM_MB*ID_W-1:0] mb_id,
    output logic [2:0]             win_idx,
    output logic                   win_valid
);
    logic [ID_W-1:0] best_id;

    // Strict less-than keeps the earlier (lower) index on equal IDs.
    always_comb begin
        win_idx   = '0;
        win_valid = 1'b0;
        best_id   = '1;
        for (int i = 0; i < NUM_MB; i++) begin
            if (pend[i] && (!win_valid || (mb_id[i*ID_W +: ID_W] < best_id))) begin
                win_valid = 1'b1;
                win_idx   = 3'(i);
                best_id   = mb_id[i*ID_W +: ID_W];
            end
        end
    end
endmodule

// File: rtl/canbus_tx_scheduler.sv
// Shares one CAN frame transmitter between NUM_MB mailboxes: ID arbitration,
// nACK/timeout retries and inter-frame spacing.
module canbus_tx_scheduler
    import canbus_pkg::*;
#(
    parameter int NUM_MB        = 4,
    parameter int DATA_BITS     = 32,
    parameter int MAX_RETRY     = 3,
    parameter int IFS_TICKS     = 11,
    parameter int TIMEOUT_TICKS = 200
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        tick,
    input  logic                        enable,
    input  logic [NUM_MB-1:0]           mb_req,
    input  logic [NUM_MB*ID_W-1:0]      mb_id,
    input  logic [NUM_MB*DATA_BITS-1:0] mb_data,
    output logic [NUM_MB-1:0]           mb_done,
    output logic [NUM_MB-1:0]           mb_err,
    output logic                        frm_start,
    output logic [ID_W-1:0]             frm_id,
    output logic [DATA_BITS-1:0]        frm_data,
    input  logic                        frm_done,
    input  logic                        frm_acked,
    output logic [2:0]                  active_mb,
    output logic [7:0]                  retry_cnt
);
    localparam int CNT_W = 16;

    sched_state_t         state;
    logic [NUM_MB-1:0]    pend;
    logic [CNT_W-1:0]     tmo_cnt;
    logic [CNT_W-1:0]     gap_cnt;
    logic [CNT_W-1:0]     gap_next;
    logic [7:0]           attempts;
    logic                 retry_pend;
    logic [2:0]           win_idx;
    logic                 win_valid;
    logic [ID_W-1:0]      sel_id;
    logic [DATA_BITS-1:0] sel_data;
    logic                 attempt_end;
    logic                 attempt_ok;
    logic                 give_up;
    logic [NUM_MB-1:0]    active_oh;
    logic [NUM_MB-1:0]    finish_mask;

    canbus_sched_pick #(.NUM_MB(NUM_MB)) u_pick (
        .pend      (pend),
        .mb_id     (mb_id),
        .win_idx   (win_idx),
        .win_valid (win_valid)
    );

    always_comb begin
        sel_id   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_MB; i++) begin
            if (win_idx == 3'(i)) begin
                sel_id   = mb_id[i*ID_W +: ID_W];
                sel_data = mb_data[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    // A timeout is a nACK attempt; a real frm_done in the same clk decides the outcome.
    always_comb begin
        attempt_end = (state == WAIT) &&
                      (frm_done || (tick && (tmo_cnt >= CNT_W'(TIMEOUT_TICKS - 1))));
        attempt_ok  = (state == WAIT) && frm_done && frm_acked;
        give_up     = attempt_end && !attempt_ok && (attempts >= 8'(MAX_RETRY));
        gap_next    = gap_cnt + CNT_W'(tick);
        for (int i = 0; i < NUM_MB; i++) begin
            active_oh[i] = (active_mb == 3'(i));
        end
        finish_mask = (attempt_ok || give_up) ? active_oh : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pend       <= '0;
            tmo_cnt    <= '0;
            gap_cnt    <= '0;
            attempts   <= '0;
            retry_pend <= 1'b0;
            mb_done    <= '0;
            mb_err     <= '0;
            frm_start  <= 1'b0;
            frm_id     <= '0;
            frm_data   <= '0;
            active_mb  <= '0;
            retry_cnt  <= '0;
        end else begin
            pend      <= (pend | mb_req) & ~finish_mask;
            mb_done   <= '0;
            mb_err    <= '0;
            frm_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && (pend != '0)) state <= ARB;
                end
                ARB: begin
                    if (win_valid) begin
                        active_mb <= win_idx;
                        frm_id    <= sel_id;
                        frm_data  <= sel_data;
                        attempts  <= '0;
                        frm_start <= 1'b1;
                        state     <= LAUNCH;
                    end else begin
                        state <= IDLE;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= CNT_W'(tick);
                    state   <= WAIT;
                end
                WAIT: begin
                    if (attempt_end) begin
                        gap_cnt <= CNT_W'(tick);
                        state   <= GAP;
                        if (attempt_ok) begin
                            mb_done <= finish_mask;
                        end else if (give_up) begin
                            mb_err <= finish_mask;
                        end else begin
                            attempts   <= attempts + 8'd1;
                            retry_pend <= 1'b1;
                            if (retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
                        end
                    end else if (tick) begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                GAP: begin
                    // A pending retry keeps the bus without re-arbitration.
                    if (gap_next >= CNT_W'(IFS_TICKS)) begin
                        retry_pend <= 1'b0;
                        if (retry_pend && enable) begin
                            frm_start <= 1'b1;
                            state     <= LAUNCH;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_canbus_tx_scheduler.sv
// Directed self-checking bench for canbus_tx_scheduler with hand-computed expectations.
module tb_canbus_tx_scheduler;
    import canbus_pkg::*;

    localparam int NUM_MB    = 4;
    localparam int DATA_BITS = 32;

    logic                        clk = 1'b0;
    logic                        rst_n = 1'b0;
    logic                        tick = 1'b0;
    logic                        enable = 1'b0;
    logic [NUM_MB-1:0]           mb_req = '0;
    logic [NUM_MB*ID_W-1:0]      mb_id = '0;
    logic [NUM_MB*DATA_BITS-1:0] mb_data = '0;
    logic [NUM_MB-1:0]           mb_done;
    logic [NUM_MB-1:0]           mb_err;
    logic                        frm_start;
    logic [ID_W-1:0]             frm_id;
    logic [DATA_BITS-1:0]        frm_data;
    logic                        frm_done = 1'b0;
    logic                        frm_acked = 1'b0;
    logic [2:0]                  active_mb;
    logic [7:0]                  retry_cnt;

    int total = 0;
    int bad = 0;
    int n_start = 0;
    int n_done = 0;
    int n_err = 0;
    logic [NUM_MB-1:0] done_seen = '0;
    logic [NUM_MB-1:0] err_seen = '0;
    int start_mb[$];
    logic [ID_W-1:0]      last_id = '0;
    logic [DATA_BITS-1:0] last_data = '0;

    always #5 clk = ~clk;

    canbus_tx_scheduler #(
        .NUM_MB(NUM_MB), .DATA_BITS(DATA_BITS), .MAX_RETRY(3),
        .IFS_TICKS(11), .TIMEOUT_TICKS(200)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .enable(enable),
        .mb_req(mb_req), .mb_id(mb_id), .mb_data(mb_data),
        .mb_done(mb_done), .mb_err(mb_err),
        .frm_start(frm_start), .frm_id(frm_id), .frm_data(frm_data),
        .frm_done(frm_done), .frm_acked(frm_acked),
        .active_mb(active_mb), .retry_cnt(retry_cnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: drive tick/frm_done/frm_acked, then observe outputs at the falling edge.
    task automatic applyStimulus(input logic t, input logic d, input logic a);
        tick      = t;
        frm_done  = d;
        frm_acked = a;
        @(negedge clk);
        if (frm_start) begin
            n_start++;
            start_mb.push_back(int'(active_mb));
            last_id   = frm_id;
            last_data = frm_data;
        end
        if (mb_done != '0) begin
            n_done++;
            done_seen |= mb_done;
        end
        if (mb_err != '0) begin
            n_err++;
            err_seen |= mb_err;
        end
        tick      = 1'b0;
        frm_done  = 1'b0;
        frm_acked = 1'b0;
    endtask

    task automatic runCycles(input int n, input logic t);
        for (int k = 0; k < n; k++) applyStimulus(t, 1'b0, 1'b0);
    endtask

    task automatic runUntilStart(input int budget, input logic t, input string tag);
        int s0;
        int k;
        s0 = n_start;
        k  = 0;
        while ((n_start == s0) && (k < budget)) begin
            applyStimulus(t, 1'b0, 1'b0);
            k++;
        end
        checkOutput(tag, 64'(n_start != s0), 64'd1);
    endtask

    // From the LAUNCH clk: move into WAIT, hold a clk, then report the attempt result.
    task automatic sendFrame(input logic ack);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, ack);
    endtask

    task automatic setMb(input int i, input logic [ID_W-1:0] id, input logic [DATA_BITS-1:0] data);
        mb_id[i*ID_W +: ID_W]           = id;
        mb_data[i*DATA_BITS +: DATA_BITS] = data;
    endtask

    task automatic pulseReq(input logic [NUM_MB-1:0] req);
        mb_req = req;
        applyStimulus(1'b0, 1'b0, 1'b0);
        mb_req = '0;
    endtask

    initial begin
        int s0;
        int d0;
        int e0;
        int base;

        runCycles(3, 1'b0);
        checkOutput("rst_frm_start", 64'(frm_start), 64'd0);
        checkOutput("rst_frm_id", 64'(frm_id), 64'd0);
        checkOutput("rst_frm_data", 64'(frm_data), 64'd0);
        checkOutput("rst_pulses", 64'({mb_done, mb_err}), 64'd0);
        checkOutput("rst_active_retry", 64'({active_mb, retry_cnt}), 64'd0);
        rst_n  = 1'b1;
        enable = 1'b1;
        runCycles(2, 1'b0);

        // Test 1: single mailbox, 3-clk launch latency, ACK first try, gap length, re-arm.
        $display("[TB] test 1: single frame");
        setMb(0, 11'h00D, 32'h12345678);
        s0 = n_start;
        mb_req = 4'b0001;
        applyStimulus(1'b0, 1'b0, 1'b0);
        mb_req = '0;
        checkOutput("t1_lat_clk1", 64'(n_start - s0), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_lat_clk2", 64'(n_start - s0), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_lat_clk3", 64'(n_start - s0), 64'd1);
        checkOutput("t1_frm_id", 64'(frm_id), 64'h00D);
        checkOutput("t1_frm_data", 64'(frm_data), 64'h12345678);
        checkOutput("t1_active", 64'(active_mb), 64'd0);
        sendFrame(1'b1);
        checkOutput("t1_one_pulse", 64'(n_start - s0), 64'd1);
        checkOutput("t1_done", 64'(done_seen), 64'b0001);
        checkOutput("t1_hold_id", 64'(frm_id), 64'h00D);
        mb_req = 4'b0001;
        applyStimulus(1'b0, 1'b0, 1'b0);
        mb_req = '0;
        runCycles(10, 1'b1);
        runCycles(20, 1'b0);
        checkOutput("t1_gap_hold", 64'(n_start - s0), 64'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_no_early", 64'(n_start - s0), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("t1_rearm_start", 64'(n_start - s0), 64'd2);
        sendFrame(1'b1);
        runCycles(11, 1'b1);
        runCycles(20, 1'b0);
        checkOutput("t1_pend_clear", 64'(n_start - s0), 64'd2);

        // Test 2: three requests in one clk, priority by ID then index.
        $display("[TB] test 2: arbitration");
        setMb(0, 11'h001, 32'hAAAA0000);
        setMb(1, 11'h00D, 32'h11111111);
        setMb(2, 11'h00D, 32'h22222222);
        setMb(3, 11'h200, 32'h33333333);
        done_seen = '0;
        d0   = n_done;
        base = start_mb.size();
        pulseReq(4'b1110);
        for (int k = 0; k < 3; k++) begin
            runUntilStart(20, 1'b0, "t2_start");
            sendFrame(1'b1);
            runCycles(11, 1'b1);
        end
        checkOutput("t2_order0", 64'(start_mb[base]), 64'd1);
        checkOutput("t2_order1", 64'(start_mb[base+1]), 64'd2);
        checkOutput("t2_order2", 64'(start_mb[base+2]), 64'd3);
        checkOutput("t2_last_data", 64'(last_data), 64'h33333333);
        checkOutput("t2_done_cnt", 64'(n_done - d0), 64'd3);
        checkOutput("t2_done_mask", 64'(done_seen), 64'b1110);

        // Test 3: never ACKed -> first attempt plus three retries, then dropped.
        $display("[TB] test 3: retries exhausted");
        setMb(0, 11'h00D, 32'h12345678);
        s0 = n_start;
        err_seen = '0;
        pulseReq(4'b0001);
        for (int k = 0; k < 4; k++) begin
            runUntilStart(40, 1'b1, "t3_start");
            sendFrame(1'b0);
        end
        checkOutput("t3_err", 64'(err_seen), 64'b0001);
        runCycles(60, 1'b1);
        checkOutput("t3_starts", 64'(n_start - s0), 64'd4);
        checkOutput("t3_retry_cnt", 64'(retry_cnt), 64'd3);

        // Test 4: timeout after 200 ticks, then frm_done on tick 200 wins.
        $display("[TB] test 4: timeout");
        s0 = n_start;
        e0 = n_err;
        done_seen = '0;
        pulseReq(4'b0001);
        runUntilStart(10, 1'b0, "t4_start");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(199, 1'b1);
        runCycles(10, 1'b0);
        checkOutput("t4_tick199_retry", 64'(retry_cnt), 64'd3);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("t4_tick200_retry", 64'(retry_cnt), 64'd4);
        runUntilStart(40, 1'b1, "t4_retry_start");
        applyStimulus(1'b0, 1'b0, 1'b0);
        runCycles(199, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("t4_done_at_200", 64'(done_seen), 64'b0001);
        checkOutput("t4_no_extra_retry", 64'(retry_cnt), 64'd4);
        runCycles(11, 1'b1);
        runCycles(20, 1'b0);
        checkOutput("t4_starts", 64'(n_start - s0), 64'd2);
        checkOutput("t4_no_err", 64'(n_err - e0), 64'd0);

        // Test 5: enable dropped during WAIT; nACK completes, relaunch waits for enable.
        $display("[TB] test 5: enable gating");
        setMb(0, 11'h0AB, 32'hDEADBEEF);
        pulseReq(4'b0001);
        runUntilStart(10, 1'b0, "t5_start");
        s0 = n_start;
        d0 = n_done;
        e0 = n_err;
        applyStimulus(1'b0, 1'b0, 1'b0);
        enable = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("t5_retry_cnt", 64'(retry_cnt), 64'd5);
        runCycles(11, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1);
        runCycles(30, 1'b1);
        checkOutput("t5_no_relaunch", 64'(n_start - s0), 64'd0);
        checkOutput("t5_stray_done", 64'(n_done - d0), 64'd0);
        checkOutput("t5_no_err", 64'(n_err - e0), 64'd0);
        enable = 1'b1;
        runUntilStart(10, 1'b0, "t5_relaunch");
        checkOutput("t5_same_mb", 64'(active_mb), 64'd0);
        checkOutput("t5_same_id", 64'(last_id), 64'h0AB);
        done_seen = '0;
        sendFrame(1'b1);
        checkOutput("t5_done", 64'(done_seen), 64'b0001);
        runCycles(11, 1'b1);

        // Test 6: asynchronous reset while a frame is in WAIT.
        $display("[TB] test 6: reset mid-frame");
        setMb(0, 11'h300, 32'h01020304);
        setMb(1, 11'h050, 32'hCAFEF00D);
        pulseReq(4'b0011);
        runUntilStart(10, 1'b0, "t6_start");
        checkOutput("t6_active", 64'(active_mb), 64'd1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_id", 64'(frm_id), 64'd0);
        checkOutput("t6_rst_data", 64'(frm_data), 64'd0);
        checkOutput("t6_rst_misc", 64'({frm_start, active_mb, retry_cnt}), 64'd0);
        runCycles(2, 1'b0);
        rst_n = 1'b1;
        s0 = n_start;
        runCycles(30, 1'b1);
        checkOutput("t6_no_start", 64'(n_start - s0), 64'd0);
        setMb(2, 11'h123, 32'h55AA55AA);
        pulseReq(4'b0100);
        runUntilStart(10, 1'b0, "t6_new_start");
        checkOutput("t6_new_active", 64'(active_mb), 64'd2);
        checkOutput("t6_new_data", 64'(frm_data), 64'h55AA55AA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
